// File: rtl/window_nxn_gen_pkg.sv
// Shared constants and helpers for the NxN window generator.
package window_nxn_gen_pkg;

  localparam int unsigned PAD_ZERO = 0;
  localparam int unsigned PAD_REPL = 1;

  // Flat element index of window element (r,c); (0,0) is the oldest/top-left.
  function automatic int unsigned elem_idx(input int unsigned r, input int unsigned c,
                                           input int unsigned win);
    return r * win + c;
  endfunction

endpackage

// File: rtl/window_nxn_gen_line_ram.sv
// Simple dual-port line RAM, one write port and one registered read port.
module line_ram_sdp #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 1920,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; padding hides stale lines.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/window_nxn_gen.sv
// Sliding WIN x WIN window generator over a raster video stream, fixed 2-cycle latency.
module window_nxn_gen
  import window_nxn_gen_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned WIN        = 3,
  parameter int unsigned IMG_WIDTH  = 1920,
  parameter int unsigned IMG_HEIGHT = 1080,
  parameter int unsigned PAD_MODE   = PAD_ZERO,
  localparam int unsigned XW        = $clog2(IMG_WIDTH),
  localparam int unsigned YW        = $clog2(IMG_HEIGHT)
) (
  input  logic                       video_clk,
  input  logic                       rst_n,
  input  logic                       video_vs,
  input  logic                       video_de,
  input  logic [DATA_W-1:0]          video_data,
  output logic                       win_vs,
  output logic                       win_de,
  output logic [WIN*WIN*DATA_W-1:0]  win_data,
  output logic [XW-1:0]              win_x,
  output logic [YW-1:0]              win_y
);

  localparam int unsigned RW = $clog2(WIN);

  if (WIN != 3 && WIN != 5) begin : g_bad_win
    $error("window_nxn_gen: WIN must be 3 or 5");
  end
  if (DATA_W < 1 || DATA_W > 16) begin : g_bad_dw
    $error("window_nxn_gen: DATA_W must be 1..16");
  end
  if (IMG_WIDTH < 2 || IMG_HEIGHT < 2) begin : g_bad_img
    $error("window_nxn_gen: image must be at least 2x2");
  end
  if (PAD_MODE > PAD_REPL) begin : g_bad_pad
    $error("window_nxn_gen: PAD_MODE must be 0 or 1");
  end

  // Position counters; a vs rising edge forces the current pixel to (0,0).
  logic          vs_prev_q;
  logic          vs_rise;
  logic [XW-1:0] x_cnt_q, pix_x;
  logic [YW-1:0] y_cnt_q, pix_y;

  assign vs_rise = video_vs & ~vs_prev_q;
  assign pix_x   = vs_rise ? '0 : x_cnt_q;
  assign pix_y   = vs_rise ? '0 : y_cnt_q;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_q <= 1'b0;
      x_cnt_q   <= '0;
      y_cnt_q   <= '0;
    end else begin
      vs_prev_q <= video_vs;
      if (video_de) begin
        if (pix_x == XW'(IMG_WIDTH - 1)) begin
          x_cnt_q <= '0;
          y_cnt_q <= (pix_y == YW'(IMG_HEIGHT - 1)) ? '0 : pix_y + 1'b1;
        end else begin
          x_cnt_q <= pix_x + 1'b1;
          y_cnt_q <= pix_y;
        end
      end else if (vs_rise) begin
        x_cnt_q <= '0;
        y_cnt_q <= '0;
      end
    end
  end

  // Stage 1: accepted pixel and its position, aligned with line-buffer read data.
  logic              de_q, vs_d1_q;
  logic [DATA_W-1:0] pix_q;
  logic [XW-1:0]     px_q;
  logic [YW-1:0]     py_q;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q    <= 1'b0;
      vs_d1_q <= 1'b0;
      pix_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      de_q    <= video_de;
      vs_d1_q <= video_vs;
      if (video_de) begin
        pix_q <= video_data;
        px_q  <= pix_x;
        py_q  <= pix_y;
      end
    end
  end

  // Cascaded line buffers: buffer i holds line y-1-i. Read at x in stage 0, write at x in stage 1.
  logic [DATA_W-1:0] lb_rd [WIN-1];
  logic [DATA_W-1:0] lb_wd [WIN-1];

  for (genvar i = 0; i < WIN - 1; i++) begin : g_lb
    if (i == 0) begin : g_first
      assign lb_wd[i] = pix_q;
    end else begin : g_next
      assign lb_wd[i] = lb_rd[i-1];
    end

    line_ram_sdp #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_WIDTH)
    ) u_line_ram (
      .clk   (video_clk),
      .we    (de_q),
      .waddr (px_q),
      .wdata (lb_wd[i]),
      .re    (video_de),
      .raddr (pix_x),
      .rdata (lb_rd[i])
    );
  end

  // Incoming column with vertical padding; rows above the frame never show buffer data.
  logic [DATA_W-1:0] raw_col [WIN];
  logic [DATA_W-1:0] col     [WIN];
  logic [RW-1:0]     top_idx;

  always_comb begin
    raw_col[WIN-1] = pix_q;
    for (int i = 0; i < int'(WIN) - 1; i++) begin
      raw_col[WIN-2-i] = lb_rd[i];
    end
    top_idx = RW'(int'(WIN) - 1 - int'(py_q));
    for (int r = 0; r < int'(WIN); r++) begin
      col[r] = raw_col[r];
      if (int'(py_q) + r < int'(WIN) - 1) begin
        col[r] = (PAD_MODE == PAD_REPL) ? raw_col[top_idx] : '0;
      end
    end
  end

  // Window shift register; at x=0 the older columns are refilled with horizontal padding.
  logic [DATA_W-1:0] win_q [WIN][WIN];
  logic [DATA_W-1:0] win_d [WIN][WIN];

  always_comb begin
    win_d = win_q;
    if (de_q) begin
      for (int r = 0; r < int'(WIN); r++) begin
        for (int c = 0; c < int'(WIN) - 1; c++) begin
          if (px_q == '0) begin
            win_d[r][c] = (PAD_MODE == PAD_REPL) ? col[r] : '0;
          end else begin
            win_d[r][c] = win_q[r][c+1];
          end
        end
        win_d[r][WIN-1] = col[r];
      end
    end
  end

  logic          win_de_q, win_vs_q;
  logic [XW-1:0] win_x_q;
  logic [YW-1:0] win_y_q;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      win_de_q <= 1'b0;
      win_vs_q <= 1'b0;
      win_x_q  <= '0;
      win_y_q  <= '0;
      for (int r = 0; r < int'(WIN); r++) begin
        for (int c = 0; c < int'(WIN); c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      win_de_q <= de_q;
      win_vs_q <= vs_d1_q;
      win_q    <= win_d;
      if (de_q) begin
        win_x_q <= px_q;
        win_y_q <= py_q;
      end
    end
  end

  for (genvar r = 0; r < WIN; r++) begin : g_row
    for (genvar c = 0; c < WIN; c++) begin : g_col
      assign win_data[elem_idx(r, c, WIN)*DATA_W +: DATA_W] = win_q[r][c];
    end
  end

  assign win_de = win_de_q;
  assign win_vs = win_vs_q;
  assign win_x  = win_x_q;
  assign win_y  = win_y_q;

endmodule
